// File: rtl/memory_controller_if.sv
// memory_controller_if: CPU-side fetch and data request/response bundle for memory_controller.
// Rev 1.0 -- mem_mc_be exists only when MC_BYTE_LANE_EN is defined.
`default_nettype none

interface memory_controller_if;
  logic        if_mc_en;
  logic [17:0] if_mc_addr;
  logic [31:0] mc_if_data;
  logic        mem_mc_en;
  logic        mem_mc_rw;
  logic [17:0] mem_mc_addr;
  logic [31:0] mem_mc_data;
  logic [31:0] mc_mem_data;
  logic        mc_stall;
`ifdef MC_BYTE_LANE_EN
  logic [3:0]  mem_mc_be;
`endif

  modport master (
    output if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_data,
    input  mc_if_data, mc_mem_data, mc_stall
`ifdef MC_BYTE_LANE_EN
    , output mem_mc_be
`endif
  );

  modport slave (
    input  if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_data,
    output mc_if_data, mc_mem_data, mc_stall
`ifdef MC_BYTE_LANE_EN
    , input mem_mc_be
`endif
  );
endinterface

`default_nettype wire

// File: rtl/memory_controller.sv
// memory_controller: serialises 32-bit fetch and data accesses onto a 16-bit async SRAM, data first.
// Rev 1.0 -- define MC_BYTE_LANE_EN to honour per-byte write enables (mem_mc_be).
`default_nettype none

module memory_controller (
  input  wire logic         clock,
  input  wire logic         reset,
  memory_controller_if.slave bus,
  output logic [17:0]       sram_addr,
  inout  wire logic [15:0]  sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MLO  = 3'd1,
    MHI  = 3'd2,
    FLO  = 3'd3,
    FHI  = 3'd4,
    OUT  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        fetch_en_q;
  logic [15:0] fetch_word_q;
  logic        mem_en_q;
  logic        mem_rw_q;
  logic [15:0] mem_word_q;
  logic [31:0] mem_wdata_q;
  logic [15:0] low_buf_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_data_q;
`ifdef MC_BYTE_LANE_EN
  logic [3:0]  mem_be_q;
`endif

  logic        drive_en;
  logic [15:0] drive_data;
  logic        addr_lsb_unused;

  // Byte offset within a word has no meaning on a word-wide port.
  assign addr_lsb_unused = ^{bus.if_mc_addr[1:0], bus.mem_mc_addr[1:0]};

  assign sram_data       = drive_en ? drive_data : 16'hzzzz;
  assign bus.mc_if_data  = if_data_q;
  assign bus.mc_mem_data = mem_data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_en_q   <= 1'b0;
      fetch_word_q <= '0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_word_q   <= '0;
      mem_wdata_q  <= '0;
      low_buf_q    <= '0;
      if_data_q    <= '0;
      mem_data_q   <= '0;
`ifdef MC_BYTE_LANE_EN
      mem_be_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        fetch_en_q   <= bus.if_mc_en;
        fetch_word_q <= bus.if_mc_addr[17:2];
        mem_en_q     <= bus.mem_mc_en;
        mem_rw_q     <= bus.mem_mc_rw;
        mem_word_q   <= bus.mem_mc_addr[17:2];
        mem_wdata_q  <= bus.mem_mc_data;
`ifdef MC_BYTE_LANE_EN
        mem_be_q     <= bus.mem_mc_be;
`endif
      end
      if ((state_q == MLO && !mem_rw_q) || state_q == FLO) begin
        low_buf_q <= sram_data;
      end
      if (state_q == MHI && !mem_rw_q) begin
        mem_data_q <= {sram_data, low_buf_q};
      end
      if (state_q == FHI) begin
        if_data_q <= {sram_data, low_buf_q};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_mc_en)     state_d = MLO;
        else if (bus.if_mc_en) state_d = FLO;
      end
      MLO:     state_d = MHI;
      MHI:     state_d = fetch_en_q ? FLO : OUT;
      FLO:     state_d = FHI;
      FHI:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_addr     = '0;
    sram_ce_n     = 1'b1;
    sram_oe_n     = 1'b1;
    sram_we_n     = 1'b1;
    sram_ub_n     = 1'b1;
    sram_lb_n     = 1'b1;
    drive_en      = 1'b0;
    drive_data    = '0;
    bus.mc_stall  = 1'b0;
    case (state_q)
      IDLE: bus.mc_stall = bus.if_mc_en | bus.mem_mc_en;
      MLO, MHI: begin
        bus.mc_stall = 1'b1;
        sram_addr    = {mem_word_q, (state_q == MHI)};
        sram_ce_n    = 1'b0;
        sram_ub_n    = 1'b0;
        sram_lb_n    = 1'b0;
        if (mem_rw_q) begin
          sram_we_n  = 1'b0;
          drive_en   = 1'b1;
          drive_data = (state_q == MHI) ? mem_wdata_q[31:16] : mem_wdata_q[15:0];
`ifdef MC_BYTE_LANE_EN
          sram_ub_n  = (state_q == MHI) ? ~mem_be_q[3] : ~mem_be_q[1];
          sram_lb_n  = (state_q == MHI) ? ~mem_be_q[2] : ~mem_be_q[0];
`endif
        end else begin
          sram_oe_n  = 1'b0;
        end
      end
      FLO, FHI: begin
        bus.mc_stall = 1'b1;
        sram_addr    = {fetch_word_q, (state_q == FHI)};
        sram_ce_n    = 1'b0;
        sram_oe_n    = 1'b0;
        sram_ub_n    = 1'b0;
        sram_lb_n    = 1'b0;
      end
      default: bus.mc_stall = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have port clock, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have port if_mc_en, input, 1, fetch read request.
REQ-004 SHALL have port if_mc_addr, input, 18, fetch byte address.
REQ-005 SHALL have port mc_if_data, output, 32, fetched instruction word (registered).
REQ-006 SHALL have port mem_mc_en, input, 1, data-stage request.
REQ-007 SHALL have port mem_mc_rw, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port mem_mc_addr, input, 18, data byte address.
REQ-009 SHALL have port mem_mc_data, input, 32, write data.
REQ-010 SHALL have port mc_mem_data, output, 32, read data (registered).
REQ-011 SHALL have port mc_stall, output, 1, global pipeline freeze.
REQ-012 SHALL have port sram_addr, output, 18, SRAM halfword address.
REQ-013 SHALL have port sram_data, inout, 16, SRAM data bus.
REQ-014 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, output, 1 each, active-low SRAM strobes.

Function
REQ-015 SHALL use an FSM with states IDLE, MLO, MHI, FLO, FHI, OUT.
REQ-016 In IDLE, SHALL latch the mem request (en, rw, addr, data) and the fetch request (en, addr) at the same edge; next state SHALL be MLO if mem is latched, else FLO if fetch is latched, else IDLE.
REQ-017 Word mapping SHALL be: low half at sram_addr = {addr[17:2],1'b0}; high half at {addr[17:2],1'b1}; addr[1:0] ignored.
REQ-018 MLO/FLO SHALL drive the low-half address; MHI/FHI SHALL drive the high-half address.
REQ-019 Reads SHALL capture sram_data at the end of the LO state into a low buffer, and at the end of the HI state SHALL load {sram_data, low buffer} into mc_mem_data (M) or mc_if_data (F).
REQ-020 Writes SHALL assert sram_we_n low and drive mem_mc_data[15:0] in MLO and [31:16] in MHI; sram_data SHALL be high-Z in every other state.
REQ-021 sram_oe_n SHALL be low only in read LO/HI states; sram_ce_n SHALL be low in LO/HI states and high otherwise.
REQ-022 MHI SHALL go to FLO if a fetch is latched, else OUT; FHI SHALL go to OUT; OUT SHALL go to IDLE.
REQ-023 Mem access SHALL precede fetch, so a fetch after a write to the same word returns the written data.
REQ-024 mc_stall SHALL be combinational: 1 in IDLE when if_mc_en or mem_mc_en is high, 1 in MLO/MHI/FLO/FHI, 0 in OUT and in idle IDLE.
REQ-025 Latency: fetch only = IDLE, FLO, FHI, OUT (3 stall cycles); mem only = 3 stall cycles; both = 5 stall cycles; data SHALL be stable in OUT.
REQ-026 mc_if_data / mc_mem_data SHALL hold their last value when not refreshed; a write SHALL not change mc_mem_data.
REQ-027 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-028 Reset low SHALL force IDLE, clear latched requests, mc_if_data = 0, mc_mem_data = 0, sram_addr = 0, all strobes high, and sram_data high-Z, within the same cycle.
REQ-029 Reset mid-access SHALL abort with no further SRAM strobes; a partial write is permitted.

Configuration
REQ-030 With macro MC_BYTE_LANE_EN defined, SHALL add input mem_mc_be [3:0] latched in IDLE; writes SHALL drive ub_n/lb_n = ~be[1]/~be[0] in MLO and ~be[3]/~be[2] in MHI; reads SHALL enable both lanes.
REQ-031 Without MC_BYTE_LANE_EN, mem_mc_be SHALL be absent and ub_n/lb_n SHALL be low in every LO/HI state.

Verification
REQ-032 Fetch only: SRAM[0x10]=0x1234, [0x11]=0xABCD, if_mc_addr=0x20 -> mc_stall high 3 cycles, then mc_if_data=0xABCD1234 in OUT.
REQ-033 Write then fetch: mem write 0xDEADBEEF to 0x40 with fetch at 0x40 -> we_n pulses in MLO/MHI, SRAM[0x20]=0xBEEF, [0x21]=0xDEAD, mc_if_data=0xDEADBEEF, 5 stall cycles.
REQ-034 Mem read: 0x0 with SRAM[0]=0x5555, [1]=0xAAAA, if_mc_en=0 -> mc_mem_data=0xAAAA5555, mc_if_data unchanged.
REQ-035 Reset asserted in MHI of a write -> next cycle IDLE, we_n/ce_n high, sram_data Z, outputs 0.
REQ-036 MC_BYTE_LANE_EN, be=4'b0100, write 0x00FF0000 to 0x8 -> only SRAM[0x5] low byte = 0xFF; other bytes unchanged.
REQ-037 No requests after reset -> mc_stall=0, FSM stays IDLE, no SRAM strobes.
